// File: rtl/rd_ptr_fwft.sv
// rd_ptr_fwft: FIFO read-pointer controller with FWFT 2-entry output buffer.
// Optional: define RDPTR_LEVEL_EN to add the registered o_rlevel port.
module rd_ptr_fwft #(
    parameter int ALEN   = 8,
    parameter int INCR   = 1,
    parameter int DLEN   = 32,
    parameter int AEMPTY = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [ALEN:0]   i_wptr,
    input  logic            i_flush,
    output logic [ALEN-1:0] o_raddr,
    output logic [ALEN:0]   o_rptr,
    output logic            o_ram_ren,
    input  logic [DLEN-1:0] i_ram_rdata,
    output logic [DLEN-1:0] o_rdata,
    output logic            o_rvalid,
    input  logic            i_rready,
    output logic            o_rempty,
    output logic            o_raempty
`ifdef RDPTR_LEVEL_EN
    ,
    output logic [ALEN+1:0] o_rlevel
`endif
);

    localparam int SH = $clog2(INCR);

    typedef enum logic [1:0] {
        B0 = 2'd0,
        B1 = 2'd1,
        B2 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ALEN:0]     rptr_q, rptr_d;
    logic              inflight_q;
    logic [DLEN-1:0]   out_q, out_d;
    logic [DLEN-1:0]   skid_q, skid_d;
    logic              raempty_q, raempty_d;
    logic              pop;
    logic              ren;
    logic              arrive;
    logic [2:0]        fill;
    logic [ALEN:0]     diff_d;
    logic [ALEN:0]     lvl_d;
    logic [ALEN+1:0]   total_d;

    // State encoding doubles as the word count
    assign cnt_q = state_q;
    assign cnt_d = state_d;

    assign o_rempty = (rptr_q == i_wptr);
    assign pop      = o_rvalid & i_rready;

    // Words held after this edge, before any new issue
    assign fill = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop};

    assign ren       = !o_rempty & !i_flush & (fill < 3'd2);
    assign arrive    = inflight_q & !i_flush;
    assign o_ram_ren = ren;

    assign o_raddr   = rptr_q[ALEN-1:0];
    assign o_rptr    = rptr_q;
    assign o_rdata   = out_q;
    assign o_raempty = raempty_q;

    // Buffer FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= B0;
        end else begin
            state_q <= state_d;
        end
    end

    // Buffer FSM next state: count follows cnt + inflight - pop
    always_comb begin
        state_d = state_q;
        if (i_flush) begin
            state_d = B0;
        end else if (fill == 3'd0) begin
            state_d = B0;
        end else if (fill == 3'd1) begin
            state_d = B1;
        end else begin
            state_d = B2;
        end
    end

    // Buffer FSM outputs
    always_comb begin
        o_rvalid = (state_q != B0);
    end

    // Steer returning RAM words into the out reg or the skid reg
    always_comb begin
        out_d  = out_q;
        skid_d = skid_q;
        if (!i_flush) begin
            unique case (state_q)
                B0: begin
                    if (arrive) out_d = i_ram_rdata;
                end
                B1: begin
                    if (arrive && pop) begin
                        out_d = i_ram_rdata;
                    end else if (arrive) begin
                        skid_d = i_ram_rdata;
                    end
                end
                default: begin
                    if (pop) begin
                        out_d = skid_q;
                        if (arrive) skid_d = i_ram_rdata;
                    end
                end
            endcase
        end
    end

    // Next read pointer and post-edge entry total
    always_comb begin
        rptr_d = rptr_q;
        if (i_flush) begin
            rptr_d = i_wptr;
        end else if (ren) begin
            rptr_d = rptr_q + (ALEN+1)'(INCR);
        end
        diff_d    = i_wptr - rptr_d;
        lvl_d     = diff_d >> SH;
        total_d   = (ALEN+2)'(lvl_d) + (ALEN+2)'(ren) + (ALEN+2)'(cnt_d);
        raempty_d = (total_d <= (ALEN+2)'(AEMPTY));
    end

    // Pointer, inflight flag and almost-empty flag registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rptr_q     <= '0;
            inflight_q <= 1'b0;
            raempty_q  <= 1'b1;
        end else begin
            rptr_q     <= rptr_d;
            inflight_q <= ren;
            raempty_q  <= raempty_d;
        end
    end

    // Output and skid data registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            out_q  <= out_d;
            skid_q <= skid_d;
        end
    end

`ifdef RDPTR_LEVEL_EN
    logic [ALEN+1:0] level_q;

    assign o_rlevel = level_q;

    // Registered total entry count; flush drives total_d to zero
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level_q <= '0;
        end else begin
            level_q <= total_d;
        end
    end
`endif

endmodule
